// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, stability filter and press pulse; DEBOUNCE_RELEASE_PULSE_EN adds KeyRelease
module key_debounce #(
  parameter  int WIDTH           = 2,
  parameter  int DEBOUNCE_CYCLES = 500000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             CLK,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Key,
  output logic [WIDTH-1:0] KeyState,
  output logic [WIDTH-1:0] KeyLevel
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  ,
  output logic [WIDTH-1:0] KeyRelease
`endif
);

  // Count value at which the next differing sample is the D-th in a row.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [CNT_W-1:0] cnt [WIDTH];

  // Two-flop synchroniser; only s2 is ever looked at by the filter.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= Key;
      s2 <= s1;
    end
  end

  // Per-channel stability counter; a level change needs DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      KeyLevel <= '0;
      KeyState <= '0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      KeyRelease <= '0;
`endif
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        KeyState[i] <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
        KeyRelease[i] <= 1'b0;
`endif
        if (s2[i] == KeyLevel[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          KeyLevel[i] <= s2[i];
          cnt[i]      <= '0;
          KeyState[i] <= s2[i];
`ifdef DEBOUNCE_RELEASE_PULSE_EN
          KeyRelease[i] <= ~s2[i];
`endif
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - randomized bench for key_debounce against a sample-window reference model
module tb_key_debounce;

  localparam int WIDTH = 2;
  localparam int D     = 4;
  localparam int NMAX  = 4096;

  logic             CLK = 1'b0;
  logic             Rst;
  logic [WIDTH-1:0] Key;
  logic [WIDTH-1:0] KeyState;
  logic [WIDTH-1:0] KeyLevel;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic [WIDTH-1:0] KeyRelease;
`endif

  int total = 0;
  int bad   = 0;

  // Stimulus history, one entry per rising edge.
  logic [WIDTH-1:0] key_h [NMAX];
  logic             rst_h [NMAX];
  int               n = 0;

  // Model outputs after the current edge.
  logic [WIDTH-1:0] m_lvl   = '0;
  logic [WIDTH-1:0] m_state = '0;
  logic [WIDTH-1:0] m_rel   = '0;
  int               last_ev [WIDTH];

  always #5 CLK = ~CLK;

  key_debounce #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(D)) dut (
    .CLK      (CLK),
    .Rst      (Rst),
    .Key      (Key),
    .KeyState (KeyState),
    .KeyLevel (KeyLevel)
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    ,
    .KeyRelease (KeyRelease)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // Key value the filter sees at edge k: the pin as sampled two edges earlier,
  // forced to 0 if either synchroniser stage was cleared by reset in between.
  function automatic logic filt_in(input int k, input int ch);
    if (k < 2) return 1'b0;
    if (rst_h[k-1] || rst_h[k-2]) return 1'b0;
    return key_h[k-2][ch];
  endfunction

  // A channel flips when the last D filter inputs all disagree with its level
  // and at least D edges have passed since its last flip or reset.
  task automatic model_edge();
    logic ok;
    m_state = '0;
    m_rel   = '0;
    if (rst_h[n]) begin
      m_lvl = '0;
      for (int ch = 0; ch < WIDTH; ch++) last_ev[ch] = n;
    end else begin
      for (int ch = 0; ch < WIDTH; ch++) begin
        if (n - last_ev[ch] >= D) begin
          ok = 1'b1;
          for (int k = n - D + 1; k <= n; k++)
            if (filt_in(k, ch) == m_lvl[ch]) ok = 1'b0;
          if (ok) begin
            m_lvl[ch] = ~m_lvl[ch];
            if (m_lvl[ch]) m_state[ch] = 1'b1;
            else           m_rel[ch]   = 1'b1;
            last_ev[ch] = n;
          end
        end
      end
    end
  endtask

  task automatic step(input logic [WIDTH-1:0] k, input logic r);
    if (n >= NMAX) begin
      $display("FAIL history_overflow edge=%0d got=%0d exp<%0d", n, n, NMAX);
      $fatal(1, "history overflow");
    end
    Key = k;
    Rst = r;
    key_h[n] = k;
    rst_h[n] = r;
    @(posedge CLK);
    #1;
    model_edge();
    check("level", 32'(KeyLevel), 32'(m_lvl));
    check("press", 32'(KeyState), 32'(m_state));
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    check("release", 32'(KeyRelease), 32'(m_rel));
`endif
    n++;
    @(negedge CLK);
  endtask

  initial begin
    int pulses;
    logic [WIDTH-1:0] cur;
    int run [WIDTH];
    logic [4:0] bounce;

    for (int ch = 0; ch < WIDTH; ch++) last_ev[ch] = 0;

    // Reset held with both keys pressed: nothing may move.
    repeat (3) step(2'b11, 1'b1);
    repeat (4) step(2'b00, 1'b0);

    // Clean press on key 0, held long: exactly one pulse.
    pulses = 0;
    repeat (56) begin
      step(2'b01, 1'b0);
      if (KeyState[0]) pulses++;
    end
    check("held_pulse_count", 32'(pulses), 32'd1);
    repeat (10) step(2'b00, 1'b0);

    // Bounce on key 1 then stable high: one pulse.
    pulses = 0;
    bounce = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      step({bounce[i], 1'b0}, 1'b0);
      if (KeyState[1]) pulses++;
    end
    repeat (14) begin
      step(2'b10, 1'b0);
      if (KeyState[1]) pulses++;
    end
    check("bounce_pulse_count", 32'(pulses), 32'd1);
    repeat (10) step(2'b00, 1'b0);

    // Three-cycle glitches never get through.
    pulses = 0;
    repeat (4) begin
      repeat (3) begin step(2'b10, 1'b0); if (KeyState[1]) pulses++; end
      repeat (3) begin step(2'b00, 1'b0); if (KeyState[1]) pulses++; end
    end
    check("glitch_pulse_count", 32'(pulses), 32'd0);

    // Simultaneous press and release.
    repeat (12) step(2'b11, 1'b0);
    repeat (12) step(2'b00, 1'b0);

    // Reset in the middle of a count, key still held afterwards.
    repeat (3) step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    repeat (12) step(2'b01, 1'b0);
    repeat (10) step(2'b00, 1'b0);

    // Random runs per channel around the debounce length, rare resets.
    cur = '0;
    for (int ch = 0; ch < WIDTH; ch++) run[ch] = 1;
    repeat (2500) begin
      for (int ch = 0; ch < WIDTH; ch++) begin
        run[ch]--;
        if (run[ch] <= 0) begin
          cur[ch] = ~cur[ch];
          run[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 20))
                                                : int'($urandom_range(1, 6));
        end
      end
      step(cur, ($urandom_range(0, 149) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
